draw_letters: RTL and testbench



---
 rtl/draw_letters_if.sv | 14 +
 rtl/draw_letters.sv | 122 ++++++++++++
 tb/tb_draw_letters.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/draw_letters_if.sv
// VGA stream bundle: counters, sync/blank strobes and pixel colour.
// Producers connect through modport out and consumers through modport in.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_letters.sv
// Board-label glyph overlay.
// The label windows are decoded from the incoming VGA sample. That sample is
// delayed for ROM_LATENCY cycles so it lines up with the font ROM row it
// addressed. The output register then paints set glyph bits in TEXT_COLOR.
// vga_in to vga_out latency is ROM_LATENCY+1 cycles, with no bubbles.
module draw_letters #(
    parameter int          ROM_LATENCY = 1,
    parameter logic [11:0] TEXT_COLOR  = 12'h0_0_0,
    parameter bit          LABEL_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_pixels,
    vga_if.in          vga_in,
    vga_if.out         vga_out
);

    // One delay-line entry: the full VGA sample plus its label decode.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
        logic        in_label;
        logic [2:0]  col;
    } stage_t;

    logic [10:0] h;
    logic [10:0] v;
    logic        top_win;
    logic        bottom_win;
    logic        left_win;
    logic        right_win;
    logic        h_span;
    logic        h_glyph;
    logic        v_span;
    logic        v_glyph;
    stage_t      stage_in;
    stage_t      stage_q [ROM_LATENCY];
    stage_t      tap;
    logic        glyph_bit;

    assign h = vga_in.hcount;
    assign v = vga_in.vcount;

    // Decode the label windows from the current input sample (inclusive bounds).
    always_comb begin
        // Rows: horizontal band 256..767 with one glyph per 64 pixels at offsets 28..35.
        h_span  = (h >= 11'd256) && (h <= 11'd767);
        h_glyph = (h[5:0] >= 6'd28) && (h[5:0] <= 6'd35);
        // Columns: vertical band 128..639 with one glyph per 64 lines at offsets 24..39.
        v_span  = (v >= 11'd128) && (v <= 11'd639);
        v_glyph = (v[5:0] >= 6'd24) && (v[5:0] <= 6'd39);

        top_win    = h_span && h_glyph && (v >= 11'd104) && (v <= 11'd119);
        bottom_win = h_span && h_glyph && (v >= 11'd648) && (v <= 11'd663);
        left_win   = (h >= 11'd236) && (h <= 11'd243) && v_span && v_glyph;
        right_win  = (h >= 11'd780) && (h <= 11'd787) && v_span && v_glyph;

        stage_in          = '0;
        stage_in.hcount   = vga_in.hcount;
        stage_in.vcount   = vga_in.vcount;
        stage_in.hsync    = vga_in.hsync;
        stage_in.vsync    = vga_in.vsync;
        stage_in.hblnk    = vga_in.hblnk;
        stage_in.vblnk    = vga_in.vblnk;
        stage_in.rgb      = vga_in.rgb;
        stage_in.in_label = LABEL_EN && (top_win || bottom_win || left_win || right_win);
        // Every window starts at hcount = 4 mod 8, so this is 0 on its first
        // pixel and wraps modulo 8 inside it.
        stage_in.col      = h[2:0] + 3'd4;
    end

    // Delay line that matches the font ROM latency and advances every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= stage_in;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tap       = stage_q[ROM_LATENCY-1];
    // Bit 7 of the ROM row is the leftmost pixel of the glyph.
    assign glyph_bit = char_pixels[3'd7 - tap.col];

    // Output register: blanking wins, then the glyph overlay, else pass-through.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= tap.hcount;
            vga_out.vcount <= tap.vcount;
            vga_out.hsync  <= tap.hsync;
            vga_out.vsync  <= tap.vsync;
            vga_out.hblnk  <= tap.hblnk;
            vga_out.vblnk  <= tap.vblnk;
            if (tap.hblnk || tap.vblnk) begin
                vga_out.rgb <= 12'h000;
            end else if (tap.in_label && glyph_bit) begin
                vga_out.rgb <= TEXT_COLOR;
            end else begin
                vga_out.rgb <= tap.rgb;
            end
        end
    end

endmodule

// File: tb/tb_draw_letters.sv
// Directed bench for draw_letters.
// dut1: latency 1 with the default colour.
// dut2: latency 2 with colour 5A3.
// dut3: latency 2 with colour 5A3 and the label overlay disabled.
module tb_draw_letters;

    localparam int W = 38;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cp1;
    logic [7:0] cp2;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] exp_q[$];

    vga_if vin ();
    vga_if vo1 ();
    vga_if vo2 ();
    vga_if vo3 ();

    logic [W-1:0] out1;
    logic [W-1:0] out2;
    logic [W-1:0] out3;

    assign out1 = {vo1.hcount, vo1.vcount, vo1.hsync, vo1.vsync, vo1.hblnk, vo1.vblnk, vo1.rgb};
    assign out2 = {vo2.hcount, vo2.vcount, vo2.hsync, vo2.vsync, vo2.hblnk, vo2.vblnk, vo2.rgb};
    assign out3 = {vo3.hcount, vo3.vcount, vo3.hsync, vo3.vsync, vo3.hblnk, vo3.vblnk, vo3.rgb};

    draw_letters #(.ROM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .char_pixels(cp1), .vga_in(vin), .vga_out(vo1)
    );
    draw_letters #(.ROM_LATENCY(2), .TEXT_COLOR(12'h5A3)) dut2 (
        .clk(clk), .rst(rst), .char_pixels(cp2), .vga_in(vin), .vga_out(vo2)
    );
    draw_letters #(.ROM_LATENCY(2), .TEXT_COLOR(12'h5A3), .LABEL_EN(1'b0)) dut3 (
        .clk(clk), .rst(rst), .char_pixels(cp2), .vga_in(vin), .vga_out(vo3)
    );

    // Clock.
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pk(input logic [10:0] h, input logic [10:0] v,
                                        input logic hs, input logic vs,
                                        input logic hb, input logic vb,
                                        input logic [11:0] c);
        return {h, v, hs, vs, hb, vb, c};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v,
                         input logic hs, input logic vs,
                         input logic hb, input logic vb,
                         input logic [11:0] c);
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = c;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One pixel through dut1: the ROM row arrives one cycle after the sample,
    // and the input moves on so that a wrong latency shows up as a wrong pixel.
    task automatic lat1_pixel(input string tag, input logic [10:0] h, input logic [10:0] v,
                              input logic hb, input logic [11:0] c,
                              input logic [7:0] cp, input logic [11:0] exp_rgb);
        drive(h, v, 1'b0, 1'b0, hb, 1'b0, c);
        step();
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        cp1 = cp;
        step();
        chk({tag, "_rgb"}, vo1.rgb, exp_rgb);
        chk({tag, "_pos"}, {vo1.hcount, vo1.vcount}, {h, v});
    endtask

    // One pixel through dut2/dut3: the ROM row arrives two cycles after the sample.
    task automatic lat2_pixel(input string tag, input logic [10:0] h, input logic [10:0] v,
                              input logic hb, input logic [11:0] c, input logic [7:0] cp,
                              input logic [11:0] exp2, input logic [11:0] exp3);
        drive(h, v, 1'b0, 1'b0, hb, 1'b0, c);
        step();
        drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        step();
        cp2 = cp;
        step();
        chk({tag, "_rgb2"}, vo2.rgb, exp2);
        chk({tag, "_pos2"}, {vo2.hcount, vo2.vcount}, {h, v});
        chk({tag, "_rgb3"}, vo3.rgb, exp3);
    endtask

    initial begin
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] c;
        logic [W-1:0] e;

        // Reset with a non-zero input applied.
        rst = 1'b1;
        cp1 = 8'hFF;
        cp2 = 8'hFF;
        drive(11'd284, 11'd110, 1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF);
        step();
        step();
        step();
        chk("reset_out1", out1, '0);
        chk("reset_out2", out2, '0);
        chk("reset_out3", out3, '0);
        rst = 1'b0;
        cp1 = 8'h00;
        cp2 = 8'h00;
        step();
        step();
        step();

        // First glyph pixel of a top-row window, leftmost bit set.
        lat1_pixel("t1_first_px", 11'd284, 11'd110, 1'b0, 12'hFFF, 8'h80, 12'h000);

        // Sweep one glyph span with only the rightmost bit set.
        cp1 = 8'h01;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive(11'(284 + i), 11'd110, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF);
            else       drive(11'd0, 11'd110, 1'b0, 1'b0, 1'b0, 1'b0, 12'hFFF);
            step();
            if (i >= 1) begin
                chk($sformatf("t2_sweep_rgb_%0d", i - 1), vo1.rgb,
                    (i - 1 == 7) ? 12'h000 : 12'hFFF);
                chk($sformatf("t2_sweep_h_%0d", i - 1), vo1.hcount, 11'(284 + i - 1));
            end
        end

        // Outside the glyph sub-windows, and around the row boundaries.
        lat1_pixel("t3_hmod44", 11'd300, 11'd110, 1'b0, 12'hABC, 8'hFF, 12'hABC);
        lat1_pixel("t3_vmod22", 11'd240, 11'd150, 1'b0, 12'hABC, 8'hFF, 12'hABC);
        lat1_pixel("t3_left_in", 11'd240, 11'd152, 1'b0, 12'hABC, 8'hFF, 12'h000);
        lat1_pixel("b_h255", 11'd255, 11'd110, 1'b0, 12'hFFF, 8'hFF, 12'hFFF);
        lat1_pixel("b_h768", 11'd768, 11'd110, 1'b0, 12'hFFF, 8'hFF, 12'hFFF);
        lat1_pixel("b_v103", 11'd284, 11'd103, 1'b0, 12'hFFF, 8'hFF, 12'hFFF);
        lat1_pixel("b_v120", 11'd284, 11'd120, 1'b0, 12'hFFF, 8'hFF, 12'hFFF);
        lat1_pixel("b_v104", 11'd284, 11'd104, 1'b0, 12'hFFF, 8'hFF, 12'h000);
        lat1_pixel("b_v119", 11'd284, 11'd119, 1'b0, 12'hFFF, 8'hFF, 12'h000);
        lat1_pixel("b_bottom", 11'd290, 11'd650, 1'b0, 12'hFFF, 8'h02, 12'h000);
        lat1_pixel("b_blank", 11'd284, 11'd110, 1'b1, 12'hFFF, 8'hFF, 12'h000);

        // Latency 2, right column, with and without the overlay enabled.
        lat2_pixel("t6_right", 11'd780, 11'd153, 1'b0, 12'hABC, 8'h80, 12'h5A3, 12'hABC);
        lat2_pixel("t6_clear", 11'd780, 11'd153, 1'b0, 12'hABC, 8'h7F, 12'hABC, 12'hABC);
        lat2_pixel("t6_last", 11'd787, 11'd153, 1'b0, 12'hABC, 8'h01, 12'h5A3, 12'hABC);
        lat2_pixel("t6_h788", 11'd788, 11'd153, 1'b0, 12'hABC, 8'hFF, 12'hABC, 12'hABC);
        lat2_pixel("t6_blank", 11'd780, 11'd153, 1'b1, 12'hABC, 8'h80, 12'h000, 12'h000);

        // Frame slice around vertical blanking, 800x600 timing, random colour.
        cp1 = 8'h00;
        exp_q.delete();
        for (int vi = 596; vi < 606; vi++) begin
            for (int hi = 0; hi < 1056; hi++) begin
                h  = 11'(hi);
                v  = 11'(vi);
                hb = (hi >= 800);
                hs = (hi >= 840) && (hi < 968);
                vb = (vi >= 600);
                vs = (vi >= 601) && (vi < 605);
                c  = 12'($urandom_range(0, 4095));
                drive(h, v, hs, vs, hb, vb, c);
                exp_q.push_back(pk(h, v, hs, vs, hb, vb, (hb || vb) ? 12'h000 : c));
                step();
                if (exp_q.size() == 2) begin
                    e = exp_q.pop_front();
                    chk($sformatf("t4_frame_%0d_%0d", vi, hi), out1, e);
                end
            end
        end

        // Reset in the middle of a line.
        exp_q.delete();
        for (int hi = 490; hi < 500; hi++) begin
            c = 12'($urandom_range(0, 4095));
            drive(11'(hi), 11'd300, 1'b1, 1'b1, 1'b0, 1'b0, c);
            exp_q.push_back(pk(11'(hi), 11'd300, 1'b1, 1'b1, 1'b0, 1'b0, c));
            step();
            if (exp_q.size() == 2) begin
                e = exp_q.pop_front();
                chk($sformatf("t5_pre_%0d", hi), out1, e);
            end
        end
        rst = 1'b1;
        exp_q.delete();
        for (int hi = 500; hi < 503; hi++) begin
            drive(11'(hi), 11'd300, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF);
            step();
            chk($sformatf("t5_rst1_%0d", hi), out1, '0);
            chk($sformatf("t5_rst2_%0d", hi), out2, '0);
        end
        rst = 1'b0;
        for (int hi = 503; hi < 516; hi++) begin
            c = 12'($urandom_range(0, 4095));
            drive(11'(hi), 11'd300, 1'b1, 1'b1, 1'b0, 1'b0, c);
            exp_q.push_back(pk(11'(hi), 11'd300, 1'b1, 1'b1, 1'b0, 1'b0, c));
            step();
            if (hi == 503) chk("t5_flush1", out1, '0);
            if (hi == 504) chk("t5_flush2", out2, '0);
            if (exp_q.size() == 2) begin
                e = exp_q.pop_front();
                chk($sformatf("t5_post_%0d", hi), out1, e);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
